// File: rtl/param_shift_unit.sv
// Sequenced shift/rotate unit: a start request either loads, retains, or runs a
// latched shift mode for 'amount' single-bit steps, then pulses done for one cycle.
module param_shift_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] amount,
   input  logic             si,
   input  logic [WIDTH-1:0] par_in,
   output logic [WIDTH-1:0] par_out,
   output logic             so,
   output logic             busy,
   output logic             done
);

   // state   | meaning
   // S_IDLE  | waiting for start; decodes mode and amount
   // S_SHIFT | one 1-bit step per clock until the counter reaches 1
   // S_DONE  | single-cycle completion pulse
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROTL = 3'b100;
   localparam logic [2:0] M_ROTR = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             so_q, so_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_data;
   logic             step_so;
   logic             is_shift;

   assign is_shift = (mode >= M_SHL) && (mode <= M_ASR);

   always_comb begin
      step_data = data_q;
      step_so   = so_q;
      case (mode_q)
         M_SHL: begin
            step_data = {data_q[WIDTH-2:0], si};
            step_so   = data_q[WIDTH-1];
         end
         M_SHR: begin
            step_data = {si, data_q[WIDTH-1:1]};
            step_so   = data_q[0];
         end
         M_ROTL: begin
            step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            step_so   = data_q[WIDTH-1];
         end
         M_ROTR: begin
            step_data = {data_q[0], data_q[WIDTH-1:1]};
            step_so   = data_q[0];
         end
         M_ASR: begin
            step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            step_so   = data_q[0];
         end
         default: begin
            step_data = data_q;
            step_so   = so_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      so_d    = so_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_DONE;
               if (mode == M_LOAD) begin
                  data_d = par_in;
               end else if (is_shift && (amount != '0)) begin
                  state_d = S_SHIFT;
                  mode_d  = mode;
                  cnt_d   = amount;
               end
            end
         end
         S_SHIFT: begin
            data_d = step_data;
            so_d   = step_so;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Outputs are registered from the next state so they line up with state_q.
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         so_q    <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= 3'b000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         so_q    <= so_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign par_out = data_q;
   assign so      = so_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_param_shift_unit.sv
// Bench for param_shift_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_param_shift_unit;
   localparam int W = 8;
   localparam int C = 4;

   logic         clock;
   logic         clear;
   logic         start;
   logic [2:0]   mode;
   logic [C-1:0] amount;
   logic         si;
   logic [W-1:0] par_in;
   logic [W-1:0] par_out;
   logic         so;
   logic         busy;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   param_shift_unit #(.WIDTH(W), .CNT_W(C)) dut (
      .clock(clock), .clear(clear), .start(start), .mode(mode), .amount(amount),
      .si(si), .par_in(par_in), .par_out(par_out), .so(so), .busy(busy), .done(done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: value and serial-out tracked as plain numbers; the
   // operation is tracked as "cycles of busy left" and "steps left".
   logic [W-1:0] m_par  = '0;
   logic         m_so   = 1'b0;
   logic [2:0]   m_mode = 3'b000;
   int           m_left = 0;
   int           m_steps = 0;

   function automatic logic [W:0] model_step(input logic [2:0] md, input logic [W-1:0] v,
                                             input logic s);
      longint unsigned x, r, sb, full, half;
      logic o;
      x    = 64'(v);
      sb   = 64'(s);
      full = 64'(1) << W;
      half = full >> 1;
      case (md)
         3'b010: begin r = (2 * x + sb) % full;        o = (x >= half);    end
         3'b011: begin r = x / 2 + sb * half;          o = (x % 2) == 1;   end
         3'b100: begin r = (2 * x) % full + x / half;  o = (x >= half);    end
         3'b101: begin r = x / 2 + (x % 2) * half;     o = (x % 2) == 1;   end
         3'b110: begin r = x / 2 + ((x >= half) ? half : 64'd0); o = (x % 2) == 1; end
         default: begin r = x; o = 1'b0; end
      endcase
      return {o, r[W-1:0]};
   endfunction

   always @(posedge clock) begin
      logic [W:0] res;
      if (clear) begin
         m_par = '0; m_so = 1'b0; m_left = 0; m_steps = 0;
      end else if (m_left > 0) begin
         if (m_steps > 0) begin
            res = model_step(m_mode, m_par, si);
            m_par = res[W-1:0];
            m_so  = res[W];
            m_steps--;
         end
         m_left--;
      end else if (start) begin
         if (mode == 3'b001) begin
            m_par  = par_in;
            m_left = 1;
         end else if (mode >= 3'b010 && mode <= 3'b110 && amount != 0) begin
            m_mode  = mode;
            m_steps = int'(amount);
            m_left  = int'(amount) + 1;
         end else begin
            m_left = 1;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         n_tests++;
         if (par_out !== m_par || so !== m_so || busy !== (m_left > 0) || done !== (m_left == 1)) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: got par=%h so=%b busy=%b done=%b, want par=%h so=%b busy=%b done=%b",
                     $time, par_out, so, busy, done, m_par, m_so, m_left > 0, m_left == 1);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] md, input logic [C-1:0] amt,
                         input logic [W-1:0] pin, input logic s, input logic [W-1:0] exp_par,
                         input logic exp_so, input int exp_lat);
      int k;
      start = 1'b1; mode = md; amount = amt; par_in = pin; si = s;
      tick();
      start = 1'b0;
      k = 1;
      while (done !== 1'b1 && k < 60) begin
         tick();
         k++;
      end
      chk({name, "_lat"}, 64'(k), 64'(exp_lat));
      chk({name, "_par"}, 64'(par_out), 64'(exp_par));
      chk({name, "_so"}, 64'(so), 64'(exp_so));
      chk({name, "_busy_at_done"}, 64'(busy), 64'd1);
      tick();
      chk({name, "_idle_after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int nb;
      clear = 1'b1; start = 1'b0; mode = 3'b000; amount = '0; si = 1'b0; par_in = '0;
      tick();
      chk_en = 1;
      tick();
      clear = 1'b0;
      chk("reset_par", 64'(par_out), 64'd0);
      chk("reset_so", 64'(so), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      tick();

      run_op("load_ad", 3'b001, 4'd0, 8'hAD, 1'b0, 8'hAD, 1'b0, 1);
      run_op("shl2", 3'b010, 4'd2, 8'h00, 1'b1, 8'hB7, 1'b0, 3);
      run_op("shr3", 3'b011, 4'd3, 8'hFF, 1'b0, 8'h16, 1'b1, 4);
      run_op("load_96", 3'b001, 4'd0, 8'h96, 1'b0, 8'h96, 1'b1, 1);
      run_op("asr2", 3'b110, 4'd2, 8'h00, 1'b0, 8'hE5, 1'b1, 3);
      run_op("shr_amt0", 3'b011, 4'd0, 8'h11, 1'b1, 8'hE5, 1'b1, 1);
      run_op("reserved", 3'b111, 4'd5, 8'h22, 1'b1, 8'hE5, 1'b1, 1);
      run_op("retain", 3'b000, 4'd3, 8'h33, 1'b0, 8'hE5, 1'b1, 1);
      run_op("load_3c", 3'b001, 4'd0, 8'h3C, 1'b0, 8'h3C, 1'b1, 1);

      // Full-width rotate with a stray start in the middle.
      start = 1'b1; mode = 3'b100; amount = 4'd8; si = 1'b1;
      tick();
      nb = 0;
      for (int k = 0; k < 40 && busy === 1'b1; k++) begin
         nb++;
         if (k == 3) begin
            start = 1'b1; mode = 3'b001; par_in = 8'hFF;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      chk("rotl8_busy_cycles", 64'(nb), 64'd9);
      chk("rotl8_par", 64'(par_out), 64'h3C);
      chk("rotl8_so", 64'(so), 64'd0);
      tick();
      chk("rotl8_no_queue", 64'(busy), 64'd0);

      // Clear two steps into a shift.
      start = 1'b1; mode = 3'b010; amount = 4'd5; si = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("abort_par", 64'(par_out), 64'd0);
      chk("abort_so", 64'(so), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      nb = 0;
      for (int k = 0; k < 6; k++) begin
         if (done === 1'b1) nb++;
         tick();
      end
      chk("abort_no_done", 64'(nb), 64'd0);

      for (int k = 0; k < 4000; k++) begin
         clear  = ($urandom_range(0, 59) == 0);
         start  = ($urandom_range(0, 2) == 0);
         mode   = 3'($urandom_range(0, 7));
         amount = C'($urandom_range(0, 15));
         si     = 1'($urandom_range(0, 1));
         par_in = W'($urandom_range(0, 255));
         tick();
      end
      clear = 1'b0; start = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
